// File: rtl/ready_table_if.sv
// Issue-queue readiness query bundle: the issue side drives source IDs per slot
// and the ready table answers with per-source ready bits in the same cycle.
interface ready_table_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int PREG_W      = 6
);
  logic [FETCH_WIDTH*PREG_W-1:0] psrc1;
  logic [FETCH_WIDTH*PREG_W-1:0] psrc2;
  logic [FETCH_WIDTH-1:0]        v1;
  logic [FETCH_WIDTH-1:0]        v2;

  modport master (output psrc1, output psrc2, input  v1, input  v2);
  modport slave  (input  psrc1, input  psrc2, output v1, output v2);
endinterface

// File: rtl/ready_table.sv
// Physical-register busy-bit table: rename clears, wake broadcasts set, flush sets all.
// Queries are combinational and see same-cycle wakes but not same-cycle allocations.
module ready_table #(
  parameter int FETCH_WIDTH      = 2,
  parameter int WAKE_NUM         = 2,
  parameter int PREG_NUM         = 64,
  parameter int PREG_W           = 6,
  parameter bit DUP_ALLOC_ASSERT = 1'b1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic [FETCH_WIDTH-1:0]        alloc_valid,
  input  logic [FETCH_WIDTH*PREG_W-1:0] alloc_preg,
  input  logic [WAKE_NUM-1:0]           wake_valid,
  input  logic [WAKE_NUM*PREG_W-1:0]    wake_preg,
  ready_table_if.slave                  rdy,
  output logic [PREG_W:0]               busy_cnt,
  output logic                          err_dup_alloc
);

  localparam int IDX_W = (PREG_NUM > 1) ? $clog2(PREG_NUM) : 1;

  // IDs wrap modulo the table size; a no-op when PREG_NUM is a power of two.
  function automatic logic [IDX_W-1:0] idx(input logic [PREG_W-1:0] id);
    return IDX_W'(32'(id) % PREG_NUM);
  endfunction

  logic [PREG_NUM-1:0] ready_q, ready_d;
  logic [PREG_W:0]     busy_cnt_q, busy_cnt_d;
  logic                err_q;
  logic [PREG_NUM-1:0] alloc_mask, wake_mask;
  logic                dup_alloc;
  logic [FETCH_WIDTH-1:0] v1_d, v2_d;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    alloc_mask = '0;
    wake_mask  = '0;
    dup_alloc  = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (alloc_valid[i]) alloc_mask[idx(alloc_preg[i*PREG_W +: PREG_W])] = 1'b1;
    for (int j = 0; j < WAKE_NUM; j++)
      if (wake_valid[j]) wake_mask[idx(wake_preg[j*PREG_W +: PREG_W])] = 1'b1;
    for (int i = 0; i < FETCH_WIDTH; i++)
      for (int k = i + 1; k < FETCH_WIDTH; k++)
        if (alloc_valid[i] && alloc_valid[k] &&
            idx(alloc_preg[i*PREG_W +: PREG_W]) == idx(alloc_preg[k*PREG_W +: PREG_W]))
          dup_alloc = 1'b1;
  end

  // Alloc wins over wake on the same entry; flush overrides both.
  always_comb begin
    ready_d    = flush ? '1 : ((ready_q | wake_mask) & ~alloc_mask);
    busy_cnt_d = '0;
    for (int k = 0; k < PREG_NUM; k++)
      busy_cnt_d += (PREG_W+1)'(!ready_d[k]);
  end

  // Query reads pre-update state, with same-cycle wakes bypassed in.
  always_comb begin
    v1_d = '0;
    v2_d = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      v1_d[i] = ready_q[idx(rdy.psrc1[i*PREG_W +: PREG_W])] |
                wake_mask[idx(rdy.psrc1[i*PREG_W +: PREG_W])];
      v2_d[i] = ready_q[idx(rdy.psrc2[i*PREG_W +: PREG_W])] |
                wake_mask[idx(rdy.psrc2[i*PREG_W +: PREG_W])];
    end
  end

  assign rdy.v1        = v1_d;
  assign rdy.v2        = v2_d;
  assign busy_cnt      = busy_cnt_q;
  assign err_dup_alloc = err_q;

  // NOTE: the ready vector is flop-based and must come out of reset all-ready,
  // so unlike a RAM it is included in the asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q    <= '1;
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      busy_cnt_q <= busy_cnt_d;
      err_q      <= err_q | (dup_alloc & ~flush);
    end
  end

  if (DUP_ALLOC_ASSERT) begin : g_dup_chk
    a_no_dup_alloc: assert property (@(posedge clk) disable iff (!resetn)
      !(dup_alloc && !flush));
  end

endmodule

// File: tb/tb_ready_table.sv
// Directed bench for ready_table: reset, alloc visibility, wake bypass,
// alloc-vs-wake priority, flush, duplicate-alloc error and async reset.
module tb_ready_table;

  localparam int FW = 2;
  localparam int WN = 2;
  localparam int PW = 6;

  logic          clk;
  logic          resetn;
  logic          flush;
  logic [FW-1:0] alloc_valid;
  logic [FW*PW-1:0] alloc_preg;
  logic [WN-1:0] wake_valid;
  logic [WN*PW-1:0] wake_preg;
  logic [PW:0]   busy_cnt;
  logic          err_dup_alloc;

  int n_checks;
  int n_fail;

  ready_table_if #(.FETCH_WIDTH(FW), .PREG_W(PW)) rdy ();

  ready_table #(
    .FETCH_WIDTH(FW), .WAKE_NUM(WN), .PREG_NUM(64), .PREG_W(PW),
    .DUP_ALLOC_ASSERT(1'b0)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
    .wake_valid(wake_valid), .wake_preg(wake_preg),
    .rdy(rdy), .busy_cnt(busy_cnt), .err_dup_alloc(err_dup_alloc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = '0;
    alloc_preg  = '0;
    wake_valid  = '0;
    wake_preg   = '0;
  endtask

  // Let one rising edge pass, return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    rdy.psrc1 = '0;
    rdy.psrc2 = '0;
    #12;
    n_checks++;
    if (busy_cnt !== 7'd0) begin
      n_fail++; $display("FAIL reset_busy_cnt got %0d want 0", busy_cnt);
    end
    n_checks++;
    if (err_dup_alloc !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got %b want 0", err_dup_alloc);
    end
    @(negedge clk);
    resetn = 1'b1;
    rdy.psrc1[0 +: PW]  = 6'd5;
    rdy.psrc2[PW +: PW] = 6'd63;
    #1;
    n_checks++;
    if (rdy.v1[0] !== 1'b1 || rdy.v2[1] !== 1'b1) begin
      n_fail++; $display("FAIL reset_query got v1[0]=%b v2[1]=%b want 1 1", rdy.v1[0], rdy.v2[1]);
    end
    tick();
    n_checks++;
    if (busy_cnt !== 7'd0) begin
      n_fail++; $display("FAIL reset_idle_busy got %0d want 0", busy_cnt);
    end
  endtask

  task automatic test_alloc_query();
    alloc_valid         = 2'b01;
    alloc_preg[0 +: PW] = 6'd7;
    rdy.psrc1[0 +: PW]  = 6'd7;
    #1;
    n_checks++;
    if (rdy.v1[0] !== 1'b1) begin
      n_fail++; $display("FAIL alloc_same_cycle got %b want 1", rdy.v1[0]);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (rdy.v1[0] !== 1'b0) begin
      n_fail++; $display("FAIL alloc_next_cycle got %b want 0", rdy.v1[0]);
    end
    n_checks++;
    if (busy_cnt !== 7'd1) begin
      n_fail++; $display("FAIL alloc_busy_cnt got %0d want 1", busy_cnt);
    end
  endtask

  task automatic test_wake_bypass();
    wake_valid         = 2'b01;
    wake_preg[0 +: PW] = 6'd7;
    rdy.psrc2[0 +: PW] = 6'd7;
    #1;
    n_checks++;
    if (rdy.v1[0] !== 1'b1 || rdy.v2[0] !== 1'b1) begin
      n_fail++; $display("FAIL wake_bypass got v1[0]=%b v2[0]=%b want 1 1", rdy.v1[0], rdy.v2[0]);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (rdy.v1[0] !== 1'b1) begin
      n_fail++; $display("FAIL wake_after got %b want 1", rdy.v1[0]);
    end
    n_checks++;
    if (busy_cnt !== 7'd0) begin
      n_fail++; $display("FAIL wake_busy_cnt got %0d want 0", busy_cnt);
    end
  endtask

  task automatic test_alloc_beats_wake();
    alloc_valid          = 2'b10;
    alloc_preg[PW +: PW] = 6'd9;
    wake_valid           = 2'b10;
    wake_preg[PW +: PW]  = 6'd9;
    rdy.psrc1[PW +: PW]  = 6'd9;
    tick();
    idle();
    #1;
    n_checks++;
    if (rdy.v1[1] !== 1'b0) begin
      n_fail++; $display("FAIL alloc_vs_wake_ready got %b want 0", rdy.v1[1]);
    end
    n_checks++;
    if (busy_cnt !== 7'd1) begin
      n_fail++; $display("FAIL alloc_vs_wake_busy got %0d want 1", busy_cnt);
    end
    // Wake through port 1 alone to release preg 9.
    wake_valid          = 2'b10;
    wake_preg[PW +: PW] = 6'd9;
    tick();
    idle();
    #1;
    n_checks++;
    if (rdy.v1[1] !== 1'b1 || busy_cnt !== 7'd0) begin
      n_fail++; $display("FAIL wake_port1 got v=%b busy=%0d want 1 0", rdy.v1[1], busy_cnt);
    end
  endtask

  task automatic test_flush();
    alloc_valid = 2'b11;
    alloc_preg  = {6'd2, 6'd1};
    tick();
    alloc_valid         = 2'b01;
    alloc_preg[0 +: PW] = 6'd3;
    tick();
    // Re-allocating busy preg 1 keeps it busy without changing the count.
    alloc_valid         = 2'b01;
    alloc_preg[0 +: PW] = 6'd1;
    tick();
    idle();
    #1;
    n_checks++;
    if (busy_cnt !== 7'd3) begin
      n_fail++; $display("FAIL flush_pre_busy got %0d want 3", busy_cnt);
    end
    n_checks++;
    if (err_dup_alloc !== 1'b0) begin
      n_fail++; $display("FAIL realloc_no_err got %b want 0", err_dup_alloc);
    end
    flush               = 1'b1;
    alloc_valid         = 2'b01;
    alloc_preg[0 +: PW] = 6'd4;
    rdy.psrc1           = {6'd2, 6'd1};
    rdy.psrc2           = {6'd4, 6'd3};
    #1;
    n_checks++;
    if (rdy.v1 !== 2'b00 || rdy.v2 !== 2'b10) begin
      n_fail++; $display("FAIL flush_cycle_query got v1=%b v2=%b want 00 10", rdy.v1, rdy.v2);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (rdy.v1 !== 2'b11 || rdy.v2 !== 2'b11) begin
      n_fail++; $display("FAIL flush_after_query got v1=%b v2=%b want 11 11", rdy.v1, rdy.v2);
    end
    n_checks++;
    if (busy_cnt !== 7'd0) begin
      n_fail++; $display("FAIL flush_busy got %0d want 0", busy_cnt);
    end
  endtask

  task automatic test_dup_alloc_reset();
    alloc_valid        = 2'b11;
    alloc_preg         = {6'd12, 6'd12};
    rdy.psrc1[0 +: PW] = 6'd12;
    tick();
    idle();
    #1;
    n_checks++;
    if (err_dup_alloc !== 1'b1) begin
      n_fail++; $display("FAIL dup_err got %b want 1", err_dup_alloc);
    end
    n_checks++;
    if (rdy.v1[0] !== 1'b0 || busy_cnt !== 7'd1) begin
      n_fail++; $display("FAIL dup_entry got v=%b busy=%0d want 0 1", rdy.v1[0], busy_cnt);
    end
    // Error stays set through an idle cycle.
    tick();
    n_checks++;
    if (err_dup_alloc !== 1'b1) begin
      n_fail++; $display("FAIL dup_sticky got %b want 1", err_dup_alloc);
    end
    // Mid-cycle asynchronous reset, together with a pending allocation.
    alloc_valid          = 2'b10;
    alloc_preg[PW +: PW] = 6'd20;
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (err_dup_alloc !== 1'b0 || busy_cnt !== 7'd0 || rdy.v1[0] !== 1'b1) begin
      n_fail++; $display("FAIL async_reset got err=%b busy=%0d v=%b want 0 0 1",
                         err_dup_alloc, busy_cnt, rdy.v1[0]);
    end
    idle();
    @(negedge clk);
    resetn = 1'b1;
    rdy.psrc2[PW +: PW] = 6'd20;
    tick();
    #1;
    n_checks++;
    if (rdy.v2[1] !== 1'b1 || busy_cnt !== 7'd0) begin
      n_fail++; $display("FAIL reset_drops_alloc got v=%b busy=%0d want 1 0", rdy.v2[1], busy_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_alloc_query();
    test_wake_bypass();
    test_alloc_beats_wake();
    test_flush();
    test_dup_alloc_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
